// File: rtl/csr_access_ctrl.sv
// Round-robin arbiter in front of the single CSR file port.
// Every access is privilege-checked; only passing accesses reach the CSR file.
module csr_access_ctrl #(
  parameter int          NUM_REQ   = 2,
  parameter logic [11:0] PROT_ADDR = 12'h064,
  parameter int          TIMEOUT   = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ-1:0]    req_we_i,
  input  logic [NUM_REQ*12-1:0] req_addr_i,
  input  logic [NUM_REQ*32-1:0] req_wdata_i,
  input  logic [NUM_REQ*2-1:0]  req_priv_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  output logic                  rsp_fault_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  csr_we_o,
  output logic                  csr_read_o,
  output logic [11:0]           csr_addr_o,
  output logic [31:0]           csr_wdata_o,
  input  logic                  csr_ack_i,
  input  logic [31:0]           csr_rdata_i,
  output logic [7:0]            fault_cnt_o
);

  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [7:0]    TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  logic [1:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win;
  logic          we_q;
  logic [11:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    priv_q;
  logic          fault_q;
  logic [31:0]   rdata_q;
  logic [7:0]    to_cnt;
  logic [7:0]    fault_cnt;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  logic [1:0] required;
  logic       chk_fault;

  always_comb begin
    required  = (addr_q == PROT_ADDR) ? 2'b11 : addr_q[9:8];
    chk_fault = (priv_q == 2'b10)
             || (priv_q < required)
             || (we_q && addr_q[11:10] == 2'b11);
  end

  logic [IW-1:0] next_ptr;

  assign next_ptr = (win == LAST_IDX) ? '0 : win + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      win       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      priv_q    <= '0;
      fault_q   <= 1'b0;
      rdata_q   <= '0;
      to_cnt    <= '0;
      fault_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            win     <= pick;
            we_q    <= req_we_i[pick];
            addr_q  <= req_addr_i[int'(pick)*12 +: 12];
            wdata_q <= req_wdata_i[int'(pick)*32 +: 32];
            priv_q  <= req_priv_i[int'(pick)*2 +: 2];
            fault_q <= 1'b0;
            rdata_q <= '0;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (chk_fault) begin
            fault_q <= 1'b1;
            state   <= S_RESP;
          end else begin
            to_cnt <= '0;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // An ack arriving on the last allowed cycle beats the timeout.
          if (csr_ack_i) begin
            rdata_q <= we_q ? 32'd0 : csr_rdata_i;
            fault_q <= 1'b0;
            state   <= S_RESP;
          end else if (to_cnt == TO_LAST) begin
            fault_q <= 1'b1;
            state   <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (fault_q && fault_cnt != 8'hFF) begin
            fault_cnt <= fault_cnt + 8'd1;
          end
          rr_ptr <= next_ptr;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (rst_ni && state == S_IDLE && found) begin
      req_ready_o[pick] = 1'b1;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state == S_RESP) begin
      rsp_valid_o[win] = 1'b1;
    end
  end

  assign rsp_fault_o = (state == S_RESP) && fault_q;
  assign rsp_rdata_o = (state == S_RESP) ? rdata_q : 32'd0;

  assign csr_we_o    = (state == S_ISSUE) && we_q;
  assign csr_read_o  = (state == S_ISSUE) && !we_q;
  assign csr_addr_o  = addr_q;
  assign csr_wdata_o = wdata_q;
  assign fault_cnt_o = fault_cnt;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: transaction model checked every cycle,
// plus directed accesses with hand-computed cycle/value expectations.
module tb_csr_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = '0;
  logic [23:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [3:0]  req_priv = '0;
  logic [1:0]  rsp_valid;
  logic        rsp_fault;
  logic [31:0] rsp_rdata;
  logic        csr_we;
  logic        csr_read;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_ack = 1'b0;
  logic [31:0] ack_data = '0;
  logic [7:0]  fault_cnt;

  int ack_at = -1;
  bit stray = 1'b0;
  int k_iss = 0;
  int total = 0;
  int bad = 0;
  int grants[$];

  csr_access_ctrl #(
    .NUM_REQ(2),
    .PROT_ADDR(12'h064),
    .TIMEOUT(TO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i(req_we),
    .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .req_priv_i(req_priv),
    .rsp_valid_o(rsp_valid),
    .rsp_fault_o(rsp_fault),
    .rsp_rdata_o(rsp_rdata),
    .csr_we_o(csr_we),
    .csr_read_o(csr_read),
    .csr_addr_o(csr_addr),
    .csr_wdata_o(csr_wdata),
    .csr_ack_i(csr_ack),
    .csr_rdata_i(ack_data),
    .fault_cnt_o(fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit rule_fault(input bit we, input logic [11:0] a,
                                    input logic [1:0] p);
    logic [1:0] need;
    need = (a == 12'h064) ? 2'b11 : a[9:8];
    return (p == 2'b10) || (p < need) || (we && a[11:10] == 2'b11);
  endfunction

  // CSR file responder: ack on the ack_at-th strobe cycle (0-based).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (csr_we || csr_read) begin
        csr_ack = (k_iss == ack_at);
        k_iss++;
      end else begin
        csr_ack = stray;
        k_iss = 0;
      end
    end
  end

  // Transaction-level model of one access in flight.
  bit          m_busy = 0, m_rsp = 0, m_iss = 0, m_flt = 0, m_we = 0;
  logic        m_rr = 1'b0, m_win = 1'b0, w = 1'b0;
  logic [11:0] m_addr = '0;
  logic [31:0] m_wdata = '0, m_rdata = '0;
  logic [1:0]  m_priv = '0;
  int          m_n = 0, m_fcnt = 0;
  logic [1:0]  e_ready, e_rv;
  bit          e_we, e_rd, hit;

  initial begin : model
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_ready = '0;
      e_rv = '0;
      e_we = 0;
      e_rd = 0;
      hit = 0;
      w = m_rr;
      if (!m_busy) begin
        if (rst_n && req_valid[m_rr]) begin
          hit = 1;
          w = m_rr;
        end else if (rst_n && req_valid[~m_rr]) begin
          hit = 1;
          w = ~m_rr;
        end
        if (hit) e_ready[w] = 1'b1;
      end else if (m_rsp) begin
        e_rv[m_win] = 1'b1;
      end else if (m_iss) begin
        e_we = m_we;
        e_rd = !m_we;
      end
      chk("m ready", 32'(req_ready), 32'(e_ready));
      chk("m rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("m csr_we", 32'(csr_we), 32'(e_we));
      chk("m csr_read", 32'(csr_read), 32'(e_rd));
      chk("m fault_cnt", 32'(fault_cnt), 32'(m_fcnt));
      if (e_rv != '0) begin
        chk("m rsp_fault", 32'(rsp_fault), 32'(m_flt));
        chk("m rsp_rdata", rsp_rdata, m_rdata);
      end
      if (m_iss && !m_rsp && m_busy) begin
        chk("m csr_addr", 32'(csr_addr), 32'(m_addr));
        chk("m csr_wdata", csr_wdata, m_wdata);
      end
      if (!rst_n) begin
        m_busy = 0;
        m_rsp = 0;
        m_iss = 0;
        m_rr = 1'b0;
        m_fcnt = 0;
      end else if (!m_busy) begin
        if (hit) begin
          m_busy = 1;
          m_win = w;
          m_we = req_we[w];
          m_addr = req_addr[w*12 +: 12];
          m_wdata = req_wdata[w*32 +: 32];
          m_priv = req_priv[w*2 +: 2];
          m_rsp = 0;
          m_iss = 0;
        end
      end else if (m_rsp) begin
        if (m_flt && m_fcnt < 255) m_fcnt++;
        m_rr = ~m_win;
        m_busy = 0;
        m_rsp = 0;
      end else if (m_iss) begin
        if (csr_ack) begin
          m_iss = 0;
          m_rsp = 1;
          m_flt = 0;
          m_rdata = m_we ? 32'd0 : ack_data;
        end else begin
          m_n++;
          if (m_n == TO) begin
            m_iss = 0;
            m_rsp = 1;
            m_flt = 1;
            m_rdata = 32'd0;
          end
        end
      end else begin
        if (rule_fault(m_we, m_addr, m_priv)) begin
          m_rsp = 1;
          m_flt = 1;
          m_rdata = 32'd0;
        end else begin
          m_iss = 1;
          m_n = 0;
        end
      end
    end
  end

  task automatic set_req(input int k, input bit we, input logic [11:0] a,
                         input logic [31:0] wd, input logic [1:0] p);
    req_we = k[0] ? {we, req_we[0]} : {req_we[1], we};
    req_addr[k*12 +: 12] = a;
    req_wdata[k*32 +: 32] = wd;
    req_priv[k*2 +: 2] = p;
  endtask

  // Called and returns at a drive point (#1 after a rising edge).
  task automatic do_access(input string nm, input int k, input bit we,
                           input logic [11:0] a, input logic [31:0] wd,
                           input logic [1:0] p, input int ack_n,
                           input logic [31:0] ad, input int resp_c,
                           input bit flt, input logic [31:0] rd,
                           input int n_iss);
    int seen;
    seen = 0;
    set_req(k, we, a, wd, p);
    ack_at = ack_n;
    ack_data = ad;
    req_valid = req_valid | 2'(1 << k);
    @(negedge clk);
    chk({nm, " ready"}, 32'(req_ready), 32'(1 << k));
    @(posedge clk);
    #1;
    req_valid = req_valid & ~2'(1 << k);
    for (int c = 1; c <= resp_c; c++) begin
      @(negedge clk);
      if (csr_we || csr_read) seen++;
      if (c == resp_c) begin
        chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'(1 << k));
        chk({nm, " fault"}, 32'(rsp_fault), 32'(flt));
        chk({nm, " rdata"}, rsp_rdata, rd);
      end
    end
    chk({nm, " strobe cycles"}, 32'(seen), 32'(n_iss));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst strobes", 32'({csr_we, csr_read}), 32'd0);
    chk("rst addr", 32'(csr_addr), 32'd0);
    chk("rst wdata", csr_wdata, 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst fault", 32'(rsp_fault), 32'd0);
    chk("rst fault_cnt", 32'(fault_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_access("m read 064", 0, 0, 12'h064, 32'd0, 2'b11, 1,
              32'hCAFE_0001, 4, 0, 32'hCAFE_0001, 2);
    do_access("s write 064", 1, 1, 12'h064, 32'hDEAD_BEEF, 2'b01, -1,
              32'd0, 2, 1, 32'd0, 0);
    @(negedge clk);
    chk("fault_cnt after bypass", 32'(fault_cnt), 32'd1);
    @(posedge clk);
    #1;

    stray = 1'b1;
    ack_at = 0;
    ack_data = 32'h0000_0300;
    set_req(0, 0, 12'h300, 32'd0, 2'b11);
    set_req(1, 0, 12'h301, 32'd0, 2'b11);
    req_valid = 2'b11;
    for (int c = 0; c < 30; c++) begin
      logic [1:0] rdy, rv;
      @(negedge clk);
      rdy = req_ready;
      rv = rsp_valid;
      if (rdy != '0) grants.push_back(rdy[1] ? 1 : 0);
      @(posedge clk);
      #1;
      req_valid = (req_valid & ~rdy) | rv;
    end
    req_valid = '0;
    stray = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rr grant count", 32'(grants.size()), 32'd8);
    for (int i = 0; i < grants.size() && i < 8; i++) begin
      chk($sformatf("rr grant %0d", i), 32'(grants[i]), 32'(i % 2));
    end

    do_access("ro write c00", 0, 1, 12'hC00, 32'h5, 2'b11, -1,
              32'd0, 2, 1, 32'd0, 0);
    do_access("rsvd priv read", 1, 0, 12'h100, 32'd0, 2'b10, -1,
              32'd0, 2, 1, 32'd0, 0);
    do_access("s read 100", 0, 0, 12'h100, 32'd0, 2'b01, 0,
              32'h0000_1100, 3, 0, 32'h0000_1100, 1);
    do_access("m write 340", 1, 1, 12'h340, 32'hA5A5_0340, 2'b11, 0,
              32'hFFFF_FFFF, 3, 0, 32'd0, 1);
    @(negedge clk);
    chk("fault_cnt after ro/rsvd", 32'(fault_cnt), 32'd3);
    @(posedge clk);
    #1;

    do_access("timeout", 0, 0, 12'h300, 32'd0, 2'b11, -1,
              32'd0, 2 + TO, 1, 32'd0, TO);
    do_access("ack on last", 1, 0, 12'h301, 32'd0, 2'b11, TO - 1,
              32'h5A5A_0003, 2 + TO, 0, 32'h5A5A_0003, TO);
    @(negedge clk);
    chk("fault_cnt after timeout", 32'(fault_cnt), 32'd4);
    @(posedge clk);
    #1;

    set_req(0, 0, 12'h300, 32'd0, 2'b11);
    ack_at = -1;
    req_valid = 2'b01;
    @(negedge clk);
    chk("rst-mid ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst-mid issuing", 32'(csr_read), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst-mid strobes", 32'({csr_we, csr_read}), 32'd0);
    chk("rst-mid rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst-mid fault_cnt", 32'(fault_cnt), 32'd0);
    chk("rst-mid addr", 32'(csr_addr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_access("after reset", 1, 0, 12'h301, 32'd0, 2'b11, 0,
              32'h0BAD_F00D, 3, 0, 32'h0BAD_F00D, 1);
    repeat (2) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
